// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used both for operand magnitudes and result sign fix.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] val_o
);

    // Wraps mod 2^WIDTH, so the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    assign val_o = neg_i ? negate(val_i) : val_i;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU unit returning {remainder, quotient} for HI/LO.
// Optional macro DIV_EARLY_TERM_EN: shortcut to the result when |opa| < |opb|.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   zero_q;
    logic               accept, by_zero, early_term, last_step;
    logic [WIDTH:0]     step_shift, step_diff;
    logic               step_bit;
    logic [WIDTH-1:0]   step_rem, step_quo, fix_q, fix_r;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .neg_i (signed_i & opa_i[WIDTH-1]),
        .val_i (opa_i),
        .val_o (abs_a)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .neg_i (signed_i & opb_i[WIDTH-1]),
        .val_i (opb_i),
        .val_o (abs_b)
    );

    assign zero_q    = {WIDTH{DIV_ZERO_Q[0]}};
    assign accept    = start_i & ~annul_i;
    assign by_zero   = (opb_i == '0);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_TERM_EN
    assign early_term = ~by_zero && (abs_a < abs_b);
`else
    assign early_term = 1'b0;
`endif

    // One restoring step: the subtract is one bit wider than the operands.
    assign step_shift = {rem_q, quo_q[WIDTH-1]};
    assign step_diff  = step_shift - {1'b0, dsr_q};
    assign step_bit   = ~step_diff[WIDTH];
    assign step_rem   = step_bit ? step_diff[WIDTH-1:0] : step_shift[WIDTH-1:0];
    assign step_quo   = {quo_q[WIDTH-2:0], step_bit};

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .neg_i (neg_q_q),
        .val_i (step_quo),
        .val_o (fix_q)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .neg_i (neg_r_q),
        .val_i (step_rem),
        .val_o (fix_r)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dsr_q   <= dsr_d;
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (by_zero || early_term) ? BYZERO : ON;
                end
            end
            BYZERO: state_d = annul_i ? IDLE : END;
            ON: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = END;
                end
            end
            END: begin
                if (!start_i || annul_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    neg_q_d = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                    neg_r_d = signed_i & opa_i[WIDTH-1];
                    dsr_d   = abs_b;
                    // Short paths preload the final {rem, quo}; BYZERO just publishes them.
                    if (by_zero) begin
                        rem_d = opa_i;
                        quo_d = zero_q;
                    end else if (early_term) begin
                        rem_d = opa_i;
                        quo_d = '0;
                    end else begin
                        rem_d = '0;
                        quo_d = abs_a;
                    end
                end
            end
            BYZERO: begin
                if (!annul_i) begin
                    result_d = {rem_q, quo_q};
                end
            end
            ON: begin
                cnt_d = cnt_q + CNT_W'(1);
                rem_d = step_rem;
                quo_d = step_quo;
                if (!annul_i && last_step) begin
                    result_d = {fix_r, fix_q};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == END);
        result_o = result_q;
        stall_o  = start_i & ~ready_o & ~annul_i;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider that serves the execute-stage DIV/DIVU request raised by the pipeline controller.
- It accepts the operands and holds the pipeline through a stall request while it iterates.
- It returns {HI, LO} = {remainder, quotient} for the HI/LO register write.
- It sits beside the ALU in the execute stage and feeds the hazard unit's stall logic.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start_i  input  1  divide request from execute stage; held high by the pipeline until ready_o is seen.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- annul_i  input  1  execute-stage flush; cancels any operation in flight.
- opa_i  input  WIDTH  dividend.
- opb_i  input  WIDTH  divisor.
- result_o  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  output  1  result_o valid.
- stall_o  output  1  stall request to hazard unit.

Behaviour:
- Reset (rst==0 at a clock edge) forces:
  - state IDLE, counter 0, result_o 0, ready_o 0.
  - Reset mid-operation abandons the division with no output.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - If start_i && !annul_i: latch operands and signed_i.
  - Next state is BYZERO if opb_i==0, otherwise ON.
  - Signed mode latches |opa_i| and |opb_i| and records sign_q = opa[MSB]^opb[MSB] and sign_r = opa[MSB].
- ON:
  - One restoring step per cycle: shift {rem, dividend} left by 1, trial-subtract divisor, set quotient bit if result is non-negative.
  - Counter runs 0..WIDTH-1; after the WIDTH-th step go to END.
  - Sign fix is applied when entering END: quotient negated if sign_q, remainder negated if sign_r.
- BYZERO: one cycle, then END with quotient = all ones and remainder = original opa_i.
- END:
  - ready_o=1 and result_o holds the result.
  - Return to IDLE when start_i==0 or annul_i==1; ready_o clears in that transition.
  - result_o keeps its last value until the next END.
- annul_i in BYZERO or ON: next state IDLE, ready_o stays 0, no result is produced.
- annul_i together with start_i in IDLE: the request is ignored.
- stall_o = start_i & !ready_o & !annul_i (combinational).
- Latency, counted from the first start_i cycle in IDLE:
  - ready_o rises WIDTH+1 cycles later (33 at default).
  - Divide-by-zero rises 2 cycles later.
- Arithmetic:
  - Subtract width is WIDTH+1 bits.
  - Abs/negation wrap mod 2^WIDTH, so 0x80000000 / -1 signed gives quotient 0x80000000, remainder 0.
- Back-to-back requests: a new start is accepted only from IDLE, so there is at least one idle cycle between results.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- When defined: in IDLE, if the unsigned magnitudes satisfy |opa| < |opb| and opb != 0, go directly to END with quotient 0 and remainder = original opa_i. Latency is 2 cycles.
- When undefined: all nonzero divisors take the full WIDTH-step path. Results are identical in both builds; only latency differs.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, BYZERO, ON, END) with a 2-bit encoding;
  - the default width constant DIV_WIDTH=32;
  - the divide-by-zero quotient constant DIV_ZERO_Q = all ones.
- One sub-module div_sign_fix (combinational): conditional two's-complement negate of quotient/remainder. It is reused for the input abs stage.

Test Plan:
- Unsigned 7/2, start_i held: ready_o rises 33 cycles after start; result_o = {0x00000001, 0x00000003}; stall_o high throughout, low once ready_o=1.
- Signed -7 (0xFFFFFFF9) / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- 5/0, either mode: ready_o after 2 cycles; result_o = {0x00000005, 0xFFFFFFFF}.
- Annul: start 100/3, assert annul_i for one cycle at cycle 10. Required: state IDLE, ready_o never rises. Then start 100/3 again: result {1, 33} after 33 cycles.
- Reset: drive rst=0 at cycle 15 of a division. Next cycle ready_o=0, result_o=0, IDLE. Then start_i low: ready_o clears one cycle after start_i drops in END.
- 3/10 unsigned: quotient 0, remainder 3; ready_o after 2 cycles with DIV_EARLY_TERM_EN, after 33 cycles without.
